// File: rtl/demuxer4_reg_pkg.sv
// Shared types for the registered 1-to-4 demultiplexer.
//   LANES      : number of output lanes (fixed at 4)
//   lane_idx_t : 2-bit lane index (explicit select and round-robin counter)
//   mode_e     : steering mode, auto (round-robin) or explicit (sel input)
package demux_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        MODE_AUTO = 1'b0,
        MODE_EXPL = 1'b1
    } mode_e;

endpackage : demux_pkg

// File: rtl/demuxer4_reg_if.sv
// Bus bundle for demuxer4_reg.
//   Producer -> demux : in_valid, in_data[WIDTH], mode, sel[2], clear
//   Demux -> consumer : q[4][WIDTH], lane_full[4], frame_valid, rr_cnt[2]
// master modport is the side that feeds words in and watches the lanes;
// slave modport is the demultiplexer itself.
interface demuxer4_reg_if #(
    parameter int WIDTH = 1
);

    logic                                           in_valid;
    logic [WIDTH-1:0]                               in_data;
    logic                                           mode;
    demux_pkg::lane_idx_t                           sel;
    logic                                           clear;
    logic [demux_pkg::LANES-1:0][WIDTH-1:0]         q;
    logic [demux_pkg::LANES-1:0]                    lane_full;
    logic                                           frame_valid;
    demux_pkg::lane_idx_t                           rr_cnt;

    modport master (
        output in_valid,
        output in_data,
        output mode,
        output sel,
        output clear,
        input  q,
        input  lane_full,
        input  frame_valid,
        input  rr_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  mode,
        input  sel,
        input  clear,
        output q,
        output lane_full,
        output frame_valid,
        output rr_cnt
    );

endinterface : demuxer4_reg_if

// File: rtl/demuxer4_reg_dec2to4.sv
// 2-to-4 lane decoder producing the per-lane write enables.
//   idx    : target lane index
//   en     : word is accepted this cycle (gates every output)
//   onehot : one-hot write enable, bit i set when idx == i and en
module dec2to4
    import demux_pkg::*;
(
    input  lane_idx_t          idx,
    input  logic               en,
    output logic [LANES-1:0]   onehot
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == lane_idx_t'(gi));
        end
    endgenerate

endmodule : dec2to4

// File: rtl/demuxer4_reg.sv
// Registered 1-to-4 demultiplexer. Accepted words are steered into one of
// four lane registers, by the round-robin counter (auto mode) or by sel
// (explicit mode). A frame completes when all four lanes have been written;
// frame_valid then pulses for one cycle while q holds the whole frame.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   bus (slave)  : in_valid/in_data/mode/sel/clear in,
//                  q/lane_full/frame_valid/rr_cnt out (all registered)
module demuxer4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demuxer4_reg_if.slave        bus
);

    logic [WIDTH-1:0]   q_reg [LANES];
    logic [LANES-1:0]   lane_full_reg;
    logic [LANES-1:0]   lane_full_next;
    lane_idx_t          rr_cnt_reg;
    lane_idx_t          rr_cnt_next;
    mode_e              mode_reg;
    logic               frame_valid_reg;
    logic               frame_valid_next;

    mode_e              mode_in;
    logic               accept;
    logic               mode_chg;
    lane_idx_t          target;
    logic [LANES-1:0]   wr_en;
    logic [LANES-1:0]   full_base;
    logic [LANES-1:0]   full_merge;
    lane_idx_t          rr_base;
    logic               frame_done;

    assign mode_in  = mode_e'(bus.mode);
    assign accept   = bus.in_valid && !bus.clear;
    assign mode_chg = (mode_in != mode_reg);

    // After any mode change rr_cnt_reg is already 0 when entering auto
    // mode (explicit mode only holds it, and leaving auto zeroes it), so
    // the raw counter is the right target even in the switching cycle.
    assign target = (mode_in == MODE_EXPL) ? bus.sel : rr_cnt_reg;

    dec2to4 u_dec (
        .idx    (target),
        .en     (accept),
        .onehot (wr_en)
    );

    always_comb begin
        // A mode change abandons the partial frame; the word accepted in
        // the same cycle then starts the new frame from an empty state.
        full_base        = mode_chg ? '0 : lane_full_reg;
        rr_base          = mode_chg ? '0 : rr_cnt_reg;
        full_merge       = full_base | wr_en;
        frame_done       = accept && (&full_merge);
        lane_full_next   = frame_done ? '0 : full_merge;
        frame_valid_next = frame_done;
        rr_cnt_next      = (accept && mode_in == MODE_AUTO) ? rr_base + 2'd1 : rr_base;
        if (bus.clear) begin
            lane_full_next   = '0;
            rr_cnt_next      = '0;
            frame_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_full_reg   <= '0;
            rr_cnt_reg      <= '0;
            mode_reg        <= MODE_AUTO;
            frame_valid_reg <= 1'b0;
        end else begin
            lane_full_reg   <= lane_full_next;
            rr_cnt_reg      <= rr_cnt_next;
            mode_reg        <= mode_in;
            frame_valid_reg <= frame_valid_next;
        end
    end

    // One register per lane; only the addressed lane loads, others hold.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_reg[gi] <= '0;
                end else if (wr_en[gi]) begin
                    q_reg[gi] <= bus.in_data;
                end
            end
            assign bus.q[gi] = q_reg[gi];
        end
    endgenerate

    assign bus.lane_full   = lane_full_reg;
    assign bus.rr_cnt      = rr_cnt_reg;
    assign bus.frame_valid = frame_valid_reg;

endmodule : demuxer4_reg

// File: tb/tb_demuxer4_reg.sv
// Self-checking bench for demuxer4_reg (WIDTH=8): directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a lane-level behavioural model.
module tb_demuxer4_reg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    demuxer4_reg_if #(.WIDTH(8)) bus ();

    demuxer4_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] mq [4];
    bit         mwritten [4];
    int         mrr;
    bit         mmode;
    bit         mfv;

    function automatic int written_count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(mwritten[i]);
        return n;
    endfunction

    task automatic forget_frame();
        for (int i = 0; i < 4; i++) mwritten[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        int lane;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mq[i] = 8'h00;
            forget_frame();
            mrr   = 0;
            mmode = 1'b0;
            mfv   = 1'b0;
        end else begin
            mfv = 1'b0;
            if (bus.mode != mmode) begin
                forget_frame();
                mrr = 0;
            end
            if (bus.clear) begin
                forget_frame();
                mrr = 0;
            end else if (bus.in_valid) begin
                lane = bus.mode ? int'(bus.sel) : mrr;
                mq[lane]       = bus.in_data;
                mwritten[lane] = 1'b1;
                if (!bus.mode) mrr = (mrr + 1) % 4;
                if (written_count() == 4) begin
                    mfv = 1'b1;
                    forget_frame();
                end
            end
            mmode = bus.mode;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q", 64'(bus.q), 64'({mq[3], mq[2], mq[1], mq[0]}));
            chk("model_lane_full", 64'(bus.lane_full),
                64'({mwritten[3], mwritten[2], mwritten[1], mwritten[0]}));
            chk("model_frame_valid", 64'(bus.frame_valid), 64'(mfv));
            chk("model_rr_cnt", 64'(bus.rr_cnt), 64'(mrr));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; applies inputs for the next rising edge and
    // returns at the following falling edge with the results visible.
    task automatic drive(input logic v, input logic [7:0] d, input logic m,
                         input logic [1:0] s, input logic c, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.mode     = m;
        bus.sel      = s;
        bus.clear    = c;
        rst_n        = r;
        $display("t=%0t rst_n=%0b in_valid=%0b in_data=%02h mode=%0b sel=%0d clear=%0b",
                 $time, r, v, d, m, s, c);
        @(negedge clk);
    endtask

    task automatic aw(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic ew(input logic [1:0] s, input logic [7:0] d);
        drive(1'b1, d, 1'b1, s, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic m);
        drive(1'b0, 8'h00, m, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int gap_rr [7];
        bit gap_v  [7];
        bit cur_mode;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.clear    = 1'b0;
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset_q", 64'(bus.q), 64'h0);
        chk("reset_lane_full", 64'(bus.lane_full), 64'h0);
        chk("reset_fv", 64'(bus.frame_valid), 64'h0);
        chk("reset_rr", 64'(bus.rr_cnt), 64'h0);

        // Auto frame
        aw(8'h11); aw(8'h22); aw(8'h33);
        chk("auto_lf3", 64'(bus.lane_full), 64'h7);
        chk("auto_fv3", 64'(bus.frame_valid), 64'h0);
        aw(8'h44);
        chk("auto_q", 64'(bus.q), 64'h44332211);
        chk("auto_fv", 64'(bus.frame_valid), 64'h1);
        chk("auto_lf", 64'(bus.lane_full), 64'h0);
        chk("auto_rr", 64'(bus.rr_cnt), 64'h0);
        idle(1'b0);
        chk("auto_fv_pulse", 64'(bus.frame_valid), 64'h0);

        // Explicit mode with a lane rewrite
        ew(2'd2, 8'hA0); ew(2'd0, 8'hB0); ew(2'd2, 8'hC0); ew(2'd3, 8'hD0);
        chk("expl_lf", 64'(bus.lane_full), 64'hD);
        chk("expl_fv4", 64'(bus.frame_valid), 64'h0);
        ew(2'd1, 8'hE0);
        chk("expl_fv", 64'(bus.frame_valid), 64'h1);
        chk("expl_q2", 64'(bus.q[2]), 64'hC0);
        chk("expl_rr", 64'(bus.rr_cnt), 64'h0);

        // Auto with gaps; first cycle also switches mode back to auto
        gap_v  = '{1, 0, 0, 1, 1, 0, 1};
        gap_rr = '{1, 1, 1, 2, 3, 3, 0};
        begin
            int w = 0;
            for (int i = 0; i < 7; i++) begin
                if (gap_v[i]) begin
                    w++;
                    aw(8'(8'h30 + w));
                end else begin
                    idle(1'b0);
                end
                chk("gap_rr", 64'(bus.rr_cnt), 64'(gap_rr[i]));
                chk("gap_fv", 64'(bus.frame_valid), 64'(i == 6));
            end
        end
        chk("gap_q", 64'(bus.q), 64'h34333231);

        // Clear wins over a simultaneous valid word
        aw(8'h41); aw(8'h42);
        drive(1'b1, 8'hFF, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("clr_lf", 64'(bus.lane_full), 64'h0);
        chk("clr_rr", 64'(bus.rr_cnt), 64'h0);
        chk("clr_q", 64'(bus.q), 64'h34334241);

        // Mode flip mid-frame
        aw(8'h51); aw(8'h52); aw(8'h53);
        ew(2'd3, 8'h55);
        chk("flip_lf", 64'(bus.lane_full), 64'h8);
        chk("flip_q", 64'(bus.q), 64'h55535251);
        chk("flip_rr", 64'(bus.rr_cnt), 64'h0);
        chk("flip_fv", 64'(bus.frame_valid), 64'h0);

        // Reset mid-frame
        idle(1'b0);
        aw(8'h61); aw(8'h62);
        drive(1'b1, 8'h63, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("rst_q", 64'(bus.q), 64'h0);
        chk("rst_lf", 64'(bus.lane_full), 64'h0);
        chk("rst_rr", 64'(bus.rr_cnt), 64'h0);
        aw(8'h77);
        chk("rst_next_q", 64'(bus.q), 64'h77);
        chk("rst_next_lf", 64'(bus.lane_full), 64'h1);
        chk("rst_next_rr", 64'(bus.rr_cnt), 64'h1);

        // Randomized traffic
        cur_mode = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(15) == 0) cur_mode = ~cur_mode;
            drive(1'($urandom_range(3) != 0), 8'($urandom), cur_mode, 2'($urandom),
                  1'($urandom_range(19) == 0), 1'($urandom_range(99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demuxer4_reg

// File: doc/demuxer4_reg.md
# demuxer4_reg

Registered 1-to-4 demultiplexer, the write-side counterpart of the 4:1 muxer used in the muxer 16 tree. It takes a stream of input words and steers each accepted word into one of four lane registers, either by an explicit lane select or by an internal round-robin counter. It reports per-lane fill status and pulses a frame strobe once all four lanes of a frame have been written. It sits ahead of muxer-based readback paths: a 4-word frame is assembled here, then selected back out downstream.

## Interface
- WIDTH, 1, bits per lane word
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  in_data is accepted this cycle
- in_data  in  WIDTH  word to steer
- mode  in  1  0 = auto (round-robin counter), 1 = explicit (use sel)
- sel  in  2  target lane in explicit mode; ignored in auto mode
- clear  in  1  synchronous frame abort
- q  out  4×WIDTH  lane registers, packed [3:0][WIDTH-1:0], lane i = q[i]
- lane_full  out  4  lane i written in the current frame
- frame_valid  out  1  one-cycle pulse: q holds a complete frame
- rr_cnt  out  2  next lane in auto mode

## Operation
- Accept: in_valid=1 and clear=0. Target lane = rr_cnt if mode=0, else sel.
- On accept:
  - q[target] <= in_data.
  - lane_full[target] <= 1.
  - All other lanes hold.
- Auto mode:
  - rr_cnt increments by 1 on each accept and wraps 3→0.
  - rr_cnt holds when no word is accepted.
- Explicit mode:
  - rr_cnt holds.
  - Rewriting a lane that is already full overwrites q and leaves lane_full unchanged. The frame is not advanced.
- Frame complete: an accept that makes lane_full all ones (counting the lane written this cycle) does two things on the next edge:
  - sets frame_valid=1 for one cycle;
  - clears lane_full to 0, not to the target bit. q keeps all four words.
- Mode change: if mode differs from its registered value of the previous cycle, the frame is aborted. lane_full and rr_cnt go to 0. The word accepted in that same cycle is written to its target lane and counts as the first word of the new frame.
- clear=1:
  - lane_full=0, rr_cnt=0, frame_valid=0.
  - q holds.
  - in_valid in the same cycle is dropped; clear wins.
- Reset (rst_n=0 at an edge) has priority over everything: q=0, lane_full=0, frame_valid=0, rr_cnt=0, registered mode=0. A reset mid-frame discards the partial frame.
- in_data is never inspected; no arithmetic beyond the 2-bit wrapping counter.

## Timing
- Write latency: 1 cycle. q and lane_full reflect an accept at edge N starting at the output after edge N.
- frame_valid rises at the same edge as the fourth lane write, so q is complete whenever frame_valid=1.
- Throughput: one word per cycle. Back-to-back frames run with no bubble: in auto mode, frame_valid pulses every 4th cycle under continuous in_valid.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package demux_pkg holds:
  - localparam LANES = 4;
  - typedef logic [1:0] lane_idx_t;
  - typedef enum logic {MODE_AUTO, MODE_EXPL} mode_e.
- Sub-module dec2to4: combinational lane_idx_t to one-hot 4-bit write-enable, gated by accept. The top block instantiates it once.
- Top-level state: q, lane_full, rr_cnt, mode_q, frame_valid.

## Test plan
- Reset then auto mode, WIDTH=8; feed 0x11, 0x22, 0x33, 0x44 back-to-back → q = {0x44, 0x33, 0x22, 0x11}; frame_valid high exactly one cycle after the 4th word; lane_full = 0000; rr_cnt = 0.
- Explicit mode, writes sel=2:0xA0, sel=0:0xB0, sel=2:0xC0, sel=3:0xD0, sel=1:0xE0 → no frame_valid after the 4th write (lane_full=1101); frame_valid after the 0xE0 write; q[2]=0xC0.
- Auto mode with in_valid gaps (pattern 1,0,0,1,1,0,1) → rr_cnt advances only on accepts; frame_valid one cycle after the 4th accepted word.
- Auto mode, 2 words accepted, then clear=1 with in_valid=1 and data 0xFF → lane_full=0, rr_cnt=0, 0xFF absent from q, q[0] and q[1] unchanged.
- Auto mode, 3 words accepted, then mode flips to 1 with accept sel=3:0x55 → lane_full=1000, q[3]=0x55, rr_cnt=0, no frame_valid.
- rst_n=0 for one cycle mid-frame in auto mode → all outputs 0 the cycle after; next word lands in lane 0.
